// File: rtl/alu_pkg.sv
// Shared definitions for the ALU control decoder and the iterative execution unit.
package alu_pkg;

  localparam int unsigned XLEN_DEF = 32;
  localparam int unsigned CTRL_W   = 4;

  localparam logic [CTRL_W-1:0] ALU_ADD  = 4'b0000;
  localparam logic [CTRL_W-1:0] ALU_SUB  = 4'b0001;
  localparam logic [CTRL_W-1:0] ALU_AND  = 4'b0010;
  localparam logic [CTRL_W-1:0] ALU_OR   = 4'b0011;
  localparam logic [CTRL_W-1:0] ALU_XOR  = 4'b0100;
  localparam logic [CTRL_W-1:0] ALU_SLT  = 4'b0101;
  localparam logic [CTRL_W-1:0] ALU_SLL  = 4'b0110;
  localparam logic [CTRL_W-1:0] ALU_SRL  = 4'b0111;
  localparam logic [CTRL_W-1:0] ALU_SRA  = 4'b1000;
  localparam logic [CTRL_W-1:0] ALU_SLTU = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic logic is_shift(input logic [CTRL_W-1:0] op);
    return (op == ALU_SLL) || (op == ALU_SRL) || (op == ALU_SRA);
  endfunction

endpackage

// File: rtl/alu_single_op.sv
// Combinational single-cycle ALU ops plus signed/unsigned compares.
// Shift and illegal codes yield zero here; shifts are handled iteratively.
module alu_single_op
  import alu_pkg::*;
#(
  parameter int unsigned XLEN = XLEN_DEF
) (
  input  logic [CTRL_W-1:0] op,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic [XLEN-1:0]   result_c,
  output logic              lt_c,
  output logic              ltu_c
);

  assign lt_c  = $signed(a) < $signed(b);
  assign ltu_c = a < b;

  always_comb begin
    result_c = '0;
    case (op)
      ALU_ADD:  result_c = a + b;
      ALU_SUB:  result_c = a - b;
      ALU_AND:  result_c = a & b;
      ALU_OR:   result_c = a | b;
      ALU_XOR:  result_c = a ^ b;
      ALU_SLT:  result_c = XLEN'(lt_c);
      ALU_SLTU: result_c = XLEN'(ltu_c);
      default:  result_c = '0;
    endcase
  end

endmodule

// File: rtl/alu_iterative.sv
// ALU execution unit: single-cycle ops finish in one cycle, shifts step one
// bit per cycle. Valid/ready handshake on both sides; result held until taken.
module alu_iterative
  import alu_pkg::*;
#(
  parameter int unsigned XLEN    = XLEN_DEF,
  parameter int unsigned SHAMT_W = $clog2(XLEN)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] alu_ctrl,
  input  logic [XLEN-1:0]   a,
  input  logic [XLEN-1:0]   b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   result,
  output logic              zero,
  output logic              lt,
  output logic              ltu
);

  state_t              state_q, state_n;
  logic [XLEN-1:0]     work_q, work_n;
  logic [SHAMT_W-1:0]  count_q, count_n;
  logic [CTRL_W-1:0]   op_q, op_n;
  logic [XLEN-1:0]     result_n;
  logic                zero_n, lt_n, ltu_n;
  logic                in_ready_n, out_valid_n;

  logic [XLEN-1:0]     single_res_c;
  logic                lt_c, ltu_c;
  logic [XLEN-1:0]     shifted_c;

  alu_single_op #(.XLEN(XLEN)) u_single (
    .op       (alu_ctrl),
    .a        (a),
    .b        (b),
    .result_c (single_res_c),
    .lt_c     (lt_c),
    .ltu_c    (ltu_c)
  );

  // One-bit step of the working register for the latched shift kind.
  always_comb begin
    shifted_c = work_q;
    case (op_q)
      ALU_SLL: shifted_c = {work_q[XLEN-2:0], 1'b0};
      ALU_SRL: shifted_c = {1'b0, work_q[XLEN-1:1]};
      default: shifted_c = {work_q[XLEN-1], work_q[XLEN-1:1]};
    endcase
  end

  always_comb begin
    state_n  = state_q;
    work_n   = work_q;
    count_n  = count_q;
    op_n     = op_q;
    result_n = result;
    zero_n   = zero;
    lt_n     = lt;
    ltu_n    = ltu;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lt_n  = lt_c;
          ltu_n = ltu_c;
          op_n  = alu_ctrl;
          if (is_shift(alu_ctrl)) begin
            work_n  = a;
            count_n = b[SHAMT_W-1:0];
            if (b[SHAMT_W-1:0] == '0) begin
              result_n = a;
              zero_n   = (a == '0);
              state_n  = DONE;
            end else begin
              state_n  = SHIFT;
            end
          end else begin
            result_n = single_res_c;
            zero_n   = (single_res_c == '0);
            state_n  = DONE;
          end
        end
      end
      SHIFT: begin
        work_n  = shifted_c;
        count_n = count_q - SHAMT_W'(1);
        if (count_q == SHAMT_W'(1)) begin
          result_n = shifted_c;
          zero_n   = (shifted_c == '0);
          state_n  = DONE;
        end
      end
      DONE: begin
        // zero is only meaningful alongside out_valid
        if (out_ready) begin
          zero_n  = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
    in_ready_n  = (state_n == IDLE);
    out_valid_n = (state_n == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      work_q    <= '0;
      count_q   <= '0;
      op_q      <= '0;
      result    <= '0;
      zero      <= 1'b0;
      lt        <= 1'b0;
      ltu       <= 1'b0;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state_q   <= state_n;
      work_q    <= work_n;
      count_q   <= count_n;
      op_q      <= op_n;
      result    <= result_n;
      zero      <= zero_n;
      lt        <= lt_n;
      ltu       <= ltu_n;
      in_ready  <= in_ready_n;
      out_valid <= out_valid_n;
    end
  end

endmodule
